// File: rtl/hwpe_ctrl_package.sv
// Shared constants for the HWPE control register file: offload register word
// indices and the special ACQUIRE response codes.
package hwpe_ctrl_package;

  localparam int unsigned REGFILE_OFFLOAD_TRIGGER = 0;
  localparam int unsigned REGFILE_OFFLOAD_ACQUIRE = 1;

  localparam logic signed [31:0] RESP_ALL_CXT_BUSY          = -32'sd1;
  localparam logic signed [31:0] RESP_ANOTHER_PE_OFFLOADING = -32'sd2;

endpackage

// File: rtl/hwpe_ctrl_job_offloader.sv
// Periph-bus master that offloads job descriptors to one HWPE: acquires a
// context, programs the job registers, triggers, and tracks jobs in flight.
module hwpe_ctrl_job_offloader
  import hwpe_ctrl_package::*;
#(
  parameter  int unsigned N_IO_REGS      = 2,
  parameter  int unsigned IO_BASE_IDX    = 16,
  parameter  logic [31:0] BASE_ADDR      = 32'h0,
  parameter  int unsigned BACKOFF_CYCLES = 8,
  parameter  int unsigned MAX_RETRY      = 0,
  parameter  int unsigned N_CONTEXT      = 2,
  localparam int unsigned PEND_W         = $clog2(N_CONTEXT + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [N_IO_REGS*32-1:0] job_params_i,
  output logic [7:0]              job_id_o,
  output logic                    job_id_valid_o,
  output logic                    abort_o,
  output logic                    busy_o,
  output logic [PEND_W-1:0]       pending_o,
  input  logic                    done_evt_i,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [31:0]             add_o,
  output logic                    wen_o,
  output logic [3:0]              be_o,
  output logic [31:0]             data_o,
  input  logic [31:0]             r_data_i,
  input  logic                    r_valid_i
);

  localparam int unsigned IDX_W   = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int unsigned BO_W    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int unsigned RETRY_W = 16;

  typedef enum logic [2:0] {
    IDLE, ACQ_REQ, ACQ_RESP, BACKOFF, WR_REQ, WR_RESP, TRIG_REQ, TRIG_RESP
  } state_e;

  function automatic logic [31:0] reg_addr(input int unsigned widx);
    return BASE_ADDR + 32'(4 * widx);
  endfunction

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 wen_q, wen_d;
  logic [31:0]          add_q, add_d;
  logic [31:0]          data_q, data_d;
  logic [7:0]           job_id_q, job_id_d;
  logic                 job_id_valid_q, job_id_valid_d;
  logic                 abort_q, abort_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [BO_W-1:0]      bo_q, bo_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [31:0]          buf_q [N_IO_REGS];
  logic [31:0]          buf_d [N_IO_REGS];

  logic                 trig_ack;
  logic                 acq_busy;
  logic [IDX_W-1:0]     idx_nxt;

  assign acq_busy = ($signed(r_data_i) == RESP_ALL_CXT_BUSY) ||
                    ($signed(r_data_i) == RESP_ANOTHER_PE_OFFLOADING);
  assign idx_nxt  = idx_q + 1'b1;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    req_d          = req_q;
    wen_d          = wen_q;
    add_d          = add_q;
    data_d         = data_q;
    job_id_d       = job_id_q;
    job_id_valid_d = 1'b0;
    abort_d        = 1'b0;
    idx_d          = idx_q;
    retry_d        = retry_q;
    bo_d           = bo_q;
    buf_d          = buf_q;
    trig_ack       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          for (int k = 0; k < int'(N_IO_REGS); k++) buf_d[k] = job_params_i[32*k +: 32];
          retry_d = '0;
          state_d = ACQ_REQ;
          req_d   = 1'b1;
          wen_d   = 1'b1;
          add_d   = reg_addr(REGFILE_OFFLOAD_ACQUIRE);
          data_d  = '0;
        end
      end
      ACQ_REQ, WR_REQ, TRIG_REQ: begin
        // Request fields are registered and untouched here, so they hold until grant.
        if (gnt_i) begin
          req_d = 1'b0;
          unique case (state_q)
            ACQ_REQ: state_d = ACQ_RESP;
            WR_REQ:  state_d = WR_RESP;
            default: state_d = TRIG_RESP;
          endcase
        end
      end
      ACQ_RESP: begin
        if (r_valid_i) begin
          if (acq_busy) begin
            if ((MAX_RETRY != 0) && (32'(retry_q) + 32'd1 == MAX_RETRY)) begin
              abort_d = 1'b1;
              state_d = IDLE;
            end else begin
              retry_d = retry_q + 1'b1;
              bo_d    = '0;
              state_d = BACKOFF;
            end
          end else begin
            job_id_d = r_data_i[7:0];
            idx_d    = '0;
            state_d  = WR_REQ;
            req_d    = 1'b1;
            wen_d    = 1'b0;
            add_d    = reg_addr(IO_BASE_IDX);
            data_d   = buf_q[0];
          end
        end
      end
      BACKOFF: begin
        if (bo_q == BO_W'(BACKOFF_CYCLES - 1)) begin
          state_d = ACQ_REQ;
          req_d   = 1'b1;
          wen_d   = 1'b1;
          add_d   = reg_addr(REGFILE_OFFLOAD_ACQUIRE);
          data_d  = '0;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      WR_RESP: begin
        if (r_valid_i) begin
          req_d = 1'b1;
          wen_d = 1'b0;
          if (idx_q == IDX_W'(N_IO_REGS - 1)) begin
            state_d = TRIG_REQ;
            add_d   = reg_addr(REGFILE_OFFLOAD_TRIGGER);
            data_d  = '0;
          end else begin
            idx_d   = idx_nxt;
            state_d = WR_REQ;
            add_d   = reg_addr(IO_BASE_IDX + 32'(idx_nxt));
            data_d  = buf_q[idx_nxt];
          end
        end
      end
      TRIG_RESP: begin
        if (r_valid_i) begin
          job_id_valid_d = 1'b1;
          trig_ack       = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A trigger-ack and a done event in the same cycle cancel out.
    pend_d = pend_q;
    if (trig_ack && !done_evt_i) begin
      if (pend_q != PEND_W'(N_CONTEXT)) pend_d = pend_q + 1'b1;
    end else if (!trig_ack && done_evt_i) begin
      if (pend_q != '0) pend_d = pend_q - 1'b1;
    end

    if (clear_i) begin
      state_d        = IDLE;
      req_d          = 1'b0;
      wen_d          = 1'b1;
      add_d          = '0;
      data_d         = '0;
      job_id_d       = '0;
      job_id_valid_d = 1'b0;
      abort_d        = 1'b0;
      idx_d          = '0;
      retry_d        = '0;
      bo_d           = '0;
      pend_d         = '0;
      for (int k = 0; k < int'(N_IO_REGS); k++) buf_d[k] = '0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the previous-cycle values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      wen_q          <= 1'b1;
      add_q          <= '0;
      data_q         <= '0;
      job_id_q       <= '0;
      job_id_valid_q <= 1'b0;
      abort_q        <= 1'b0;
      idx_q          <= '0;
      retry_q        <= '0;
      bo_q           <= '0;
      pend_q         <= '0;
      // NOTE: the descriptor buffer is a handful of flops, not a RAM macro,
      // so resetting it is cheap and keeps data_o free of X after reset.
      for (int k = 0; k < int'(N_IO_REGS); k++) buf_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      wen_q          <= wen_d;
      add_q          <= add_d;
      data_q         <= data_d;
      job_id_q       <= job_id_d;
      job_id_valid_q <= job_id_valid_d;
      abort_q        <= abort_d;
      idx_q          <= idx_d;
      retry_q        <= retry_d;
      bo_q           <= bo_d;
      pend_q         <= pend_d;
      for (int k = 0; k < int'(N_IO_REGS); k++) buf_q[k] <= buf_d[k];
    end
  end

  assign job_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign job_id_o       = job_id_q;
  assign job_id_valid_o = job_id_valid_q;
  assign abort_o        = abort_q;
  assign pending_o      = pend_q;
  assign req_o          = req_q;
  assign add_o          = add_q;
  assign wen_o          = wen_q;
  assign be_o           = 4'hF;
  assign data_o         = data_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Directed bench: a scoreboard of expected bus transactions is filled as jobs and
// ACQUIRE responses are driven, and drained as the offloader issues requests.
module tb_hwpe_ctrl_job_offloader;

  localparam int NREG    = 2;
  localparam int BACKOFF = 8;

  typedef enum logic [1:0] {K_ACQ, K_WR, K_TRIG} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst, clear, job_valid, gnt, r_valid, done_evt, sel;
  logic [NREG*32-1:0] job_params;
  logic [31:0] r_data;

  logic a_ready, a_idv, a_abort, a_busy, a_req, a_wen;
  logic b_ready, b_idv, b_abort, b_busy, b_req, b_wen;
  logic [7:0]  a_id, b_id;
  logic [1:0]  a_pend, b_pend;
  logic [31:0] a_add, b_add, a_data, b_data;
  logic [3:0]  a_be, b_be;

  logic m_ready, m_idv, m_abort, m_busy, m_req, m_wen;
  logic [7:0]  m_id;
  logic [1:0]  m_pend;
  logic [31:0] m_add, m_data;
  logic [3:0]  m_be;

  assign m_ready = sel ? b_ready : a_ready;
  assign m_idv   = sel ? b_idv   : a_idv;
  assign m_abort = sel ? b_abort : a_abort;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_req   = sel ? b_req   : a_req;
  assign m_wen   = sel ? b_wen   : a_wen;
  assign m_id    = sel ? b_id    : a_id;
  assign m_pend  = sel ? b_pend  : a_pend;
  assign m_add   = sel ? b_add   : a_add;
  assign m_data  = sel ? b_data  : a_data;
  assign m_be    = sel ? b_be    : a_be;

  hwpe_ctrl_job_offloader u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .job_valid_i(job_valid & ~sel), .job_ready_o(a_ready), .job_params_i(job_params),
    .job_id_o(a_id), .job_id_valid_o(a_idv), .abort_o(a_abort), .busy_o(a_busy),
    .pending_o(a_pend), .done_evt_i(done_evt & ~sel),
    .req_o(a_req), .gnt_i(gnt & ~sel), .add_o(a_add), .wen_o(a_wen), .be_o(a_be),
    .data_o(a_data), .r_data_i(r_data), .r_valid_i(r_valid & ~sel)
  );

  hwpe_ctrl_job_offloader #(.MAX_RETRY(2)) u_dut_r (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .job_valid_i(job_valid & sel), .job_ready_o(b_ready), .job_params_i(job_params),
    .job_id_o(b_id), .job_id_valid_o(b_idv), .abort_o(b_abort), .busy_o(b_busy),
    .pending_o(b_pend), .done_evt_i(done_evt & sel),
    .req_o(b_req), .gnt_i(gnt & sel), .add_o(b_add), .wen_o(b_wen), .be_o(b_be),
    .data_o(b_data), .r_data_i(r_data), .r_valid_i(r_valid & sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  txn_t exp_q[$];
  logic [7:0] id_q[$];
  logic [NREG*32-1:0] cur_p;
  int pend_m[2];
  int retry_m;
  int req_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept_job(input logic [NREG*32-1:0] p);
    txn_t t;
    cur_p   = p;
    retry_m = 0;
    t = '{kind: K_ACQ, add: 32'h4, wen: 1'b1, data: 32'h0};
    exp_q.push_back(t);
    check("job_ready_idle", m_ready, 1'b1);
    job_params = p;
    job_valid  = 1'b1;
    tick();
    job_valid  = 1'b0;
    check("busy_after_accept", m_busy, 1'b1);
  endtask

  task automatic pulse_done();
    done_evt = 1'b1;
    tick();
    done_evt = 1'b0;
    if (pend_m[sel] > 0) pend_m[sel]--;
    check("pending_after_done", m_pend, pend_m[sel]);
  endtask

  // Wait for a request, compare it to the scoreboard, grant after gnt_wait
  // stall cycles, then return rdata and update the reference model.
  task automatic serve(input logic [31:0] rdata, input int gnt_wait, input bit done_at_resp);
    txn_t e, t;
    int n = 0;
    while (!m_req && n < 300) begin tick(); n++; end
    if (!m_req) begin check("req_timeout", m_req, 1'b1); return; end
    req_seen = cyc;
    if (exp_q.size() == 0) begin check("unexpected_req", m_req, 1'b0); return; end
    e = exp_q.pop_front();
    check("req_add", m_add, e.add);
    check("req_wen", m_wen, e.wen);
    check("req_data", m_data, e.data);
    check("req_be", m_be, 4'hF);
    check("ready_low_busy", m_ready, 1'b0);
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      check("stall_req", m_req, 1'b1);
      check("stall_add", m_add, e.add);
      check("stall_data", m_data, e.data);
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("req_drop", m_req, 1'b0);
    r_valid  = 1'b1;
    r_data   = rdata;
    done_evt = done_at_resp;
    tick();
    r_valid  = 1'b0;
    done_evt = 1'b0;
    case (e.kind)
      K_ACQ: begin
        if ($signed(rdata) == -32'sd1 || $signed(rdata) == -32'sd2) begin
          retry_m++;
          if (sel && retry_m == 2) begin
            check("abort_pulse", m_abort, 1'b1);
            check("idle_after_abort", m_busy, 1'b0);
          end else begin
            check("no_abort", m_abort, 1'b0);
            t = '{kind: K_ACQ, add: 32'h4, wen: 1'b1, data: 32'h0};
            exp_q.push_front(t);
          end
        end else begin
          check("job_id_latch", m_id, {24'h0, rdata[7:0]});
          id_q.push_back(rdata[7:0]);
          for (int k = 0; k < NREG; k++) begin
            t = '{kind: K_WR, add: 32'h40 + 32'(4 * k), wen: 1'b0, data: cur_p[32*k +: 32]};
            exp_q.push_back(t);
          end
          t = '{kind: K_TRIG, add: 32'h0, wen: 1'b0, data: 32'h0};
          exp_q.push_back(t);
        end
      end
      K_TRIG: begin
        check("job_id_valid", m_idv, 1'b1);
        if (id_q.size() > 0) check("job_id_out", m_id, {24'h0, id_q.pop_front()});
        if (!done_at_resp && pend_m[sel] < 2) pend_m[sel]++;
        check("pending_after_trig", m_pend, pend_m[sel]);
        check("idle_after_trig", m_busy, 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic run_job(input logic [31:0] id, input int gw, input bit done_last);
    accept_job({$urandom, $urandom});
    serve(id, gw, 1'b0);
    for (int k = 0; k < NREG; k++) serve(32'h0, gw, 1'b0);
    serve(32'h0, gw, done_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, r1, r2, r3, n;
    rst = 1'b1; clear = 1'b0; job_valid = 1'b0; gnt = 1'b0; r_valid = 1'b0;
    done_evt = 1'b0; sel = 1'b0; job_params = '0; r_data = '0;
    pend_m[0] = 0; pend_m[1] = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_req", m_req, 1'b0);
    check("rst_wen", m_wen, 1'b1);
    check("rst_add", m_add, 32'h0);
    check("rst_data", m_data, 32'h0);
    check("rst_job_id", m_id, 8'h0);
    check("rst_idv", m_idv, 1'b0);
    check("rst_abort", m_abort, 1'b0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_pending", m_pend, 2'd0);
    check("rst_ready", m_ready, 1'b1);

    // Basic job, zero-wait grant, latency to job_id_valid.
    accept_job(64'hCAFE_0002_1234_0001);
    acc = cyc;
    serve(32'd5, 0, 1'b0);
    serve(32'h0, 0, 1'b0);
    serve(32'h0, 0, 1'b0);
    serve(32'h0, 0, 1'b0);
    check("trigger_latency", 32'(cyc - acc), 32'd8);
    check("job_id_5", m_id, 8'd5);
    tick();
    check("idv_one_cycle", m_idv, 1'b0);

    // Done events, including one at zero.
    pulse_done();
    pulse_done();

    // Two busy responses then success, with backoff spacing.
    accept_job({$urandom, $urandom});
    serve(32'hFFFF_FFFF, 0, 1'b0); r1 = req_seen;
    serve(32'hFFFF_FFFF, 0, 1'b0); r2 = req_seen;
    serve(32'd3, 0, 1'b0);         r3 = req_seen;
    check("backoff_gap1", 32'(r2 - r1), 32'(BACKOFF + 2));
    check("backoff_gap2", 32'(r3 - r2), 32'(BACKOFF + 2));
    for (int k = 0; k < NREG; k++) serve(32'h0, 0, 1'b0);
    serve(32'h0, 0, 1'b0);
    check("job_id_3", m_id, 8'd3);

    // Trigger-ack coincident with done at pending=1.
    run_job(32'd9, 0, 1'b1);

    // Stalled grants; second job saturates pending at N_CONTEXT.
    run_job(32'd11, 5, 1'b0);
    run_job(32'd12, 5, 1'b0);
    run_job(32'd13, 0, 1'b0);
    check("pending_saturated", m_pend, 2'd2);

    // Abort after MAX_RETRY=2 failures on the second instance.
    sel = 1'b1;
    tick();
    accept_job({$urandom, $urandom});
    serve(32'hFFFF_FFFE, 0, 1'b0);
    serve(32'hFFFF_FFFE, 0, 1'b0);
    tick();
    check("abort_one_cycle", m_abort, 1'b0);
    n = 0;
    repeat (12) begin tick(); if (m_req) n++; end
    check("no_write_after_abort", 32'(n), 32'd0);
    check("abort_job_id", m_id, 8'h0);
    check("abort_ready", m_ready, 1'b1);

    // Soft clear while waiting for a write response, then a stray response.
    sel = 1'b0;
    tick();
    accept_job({$urandom, $urandom});
    serve(32'd7, 0, 1'b0);
    n = 0;
    while (!m_req && n < 50) begin tick(); n++; end
    check("wr_req_before_clear", m_req, 1'b1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pend_m[0] = 0;
    exp_q.delete();
    id_q.delete();
    check("clr_busy", m_busy, 1'b0);
    check("clr_req", m_req, 1'b0);
    check("clr_wen", m_wen, 1'b1);
    check("clr_add", m_add, 32'h0);
    check("clr_data", m_data, 32'h0);
    check("clr_job_id", m_id, 8'h0);
    check("clr_pending", m_pend, pend_m[0]);
    r_valid = 1'b1;
    r_data  = 32'h0;
    tick();
    r_valid = 1'b0;
    tick();
    check("stray_busy", m_busy, 1'b0);
    check("stray_req", m_req, 1'b0);
    check("stray_idv", m_idv, 1'b0);
    check("stray_pending", m_pend, pend_m[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
